// File: rtl/usb_command_receiver_if.sv
// FT245 read-side bus plus the command handshake toward the consumer.
// The receiver takes the master modport; the FIFO/consumer side takes slave.
interface usb_command_receiver_if;
    logic        rxf;
    logic [7:0]  data_in;
    logic        rd;
    logic        wr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic        busy;

    modport master (
        input  rxf, data_in, cmd_ready,
        output rd, wr, cmd_valid, cmd_op, cmd_data, frame_err, busy
    );

    modport slave (
        output rxf, data_in, cmd_ready,
        input  rd, wr, cmd_valid, cmd_op, cmd_data, frame_err, busy
    );
endinterface

// File: rtl/usb_command_receiver.sv
// Reads 5-byte command frames (opcode + 32-bit LSB-first argument) from an FT245
// receive FIFO and presents legal commands on a valid/ready handshake.
module usb_command_receiver #(
    parameter int unsigned RD_LOW_TICKS  = 2,
    parameter int unsigned RD_HIGH_TICKS = 2,
    parameter int unsigned TIMEOUT_TICKS = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_command_receiver_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LOW,
        S_RD_HIGH,
        S_CHECK,
        S_DELIVER
    } state_t;

    localparam int TICK_W = 16;
    localparam logic [TICK_W-1:0] LOW_LAST  = TICK_W'(RD_LOW_TICKS - 1);
    localparam logic [TICK_W-1:0] HIGH_LAST = TICK_W'(RD_HIGH_TICKS - 1);

    state_t            r_state, w_state_nx;
    logic              r_rxf_m, r_rxf_s;
    logic [2:0]        r_idx, w_idx_nx;
    logic [TICK_W-1:0] r_tick, w_tick_nx;
    logic [31:0]       r_timer, w_timer_nx;
    logic              r_rd, w_rd_nx;
    logic              r_cmd_valid, w_cmd_valid_nx;
    logic [7:0]        r_cmd_op, w_cmd_op_nx;
    logic [31:0]       r_cmd_data, w_cmd_data_nx;
    logic              r_frame_err, w_frame_err_nx;
    logic [39:0]       r_frame, w_frame_nx;
    logic              w_op_legal;

    // Byte k of the frame lives in r_frame[8k+7:8k], so [39:8] is the argument as sent.
    assign w_op_legal = (r_frame[7:2] == 6'd0);

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_tick_nx      = r_tick;
        w_timer_nx     = r_timer;
        w_rd_nx        = r_rd;
        w_cmd_valid_nx = r_cmd_valid;
        w_cmd_op_nx    = r_cmd_op;
        w_cmd_data_nx  = r_cmd_data;
        w_frame_err_nx = 1'b0;
        w_frame_nx     = r_frame;

        case (r_state)
            S_IDLE: begin
                w_rd_nx = 1'b1;
                // A stale partial frame is dropped before any new read can extend it.
                if ((r_idx != 3'd0) && (r_timer >= TIMEOUT_TICKS)) begin
                    w_idx_nx       = 3'd0;
                    w_frame_err_nx = 1'b1;
                    w_timer_nx     = 32'd0;
                end else if (!r_rxf_s) begin
                    w_rd_nx    = 1'b0;
                    w_tick_nx  = '0;
                    w_timer_nx = 32'd0;
                    w_state_nx = S_RD_LOW;
                end else if (r_idx != 3'd0) begin
                    w_timer_nx = r_timer + 32'd1;
                end
            end
            S_RD_LOW: begin
                if (r_tick == LOW_LAST) begin
                    w_frame_nx[{r_idx, 3'b000} +: 8] = bus.data_in;
                    w_rd_nx    = 1'b1;
                    w_tick_nx  = '0;
                    w_state_nx = S_RD_HIGH;
                end else begin
                    w_tick_nx = r_tick + 1'b1;
                end
            end
            S_RD_HIGH: begin
                if (r_tick == HIGH_LAST) begin
                    w_tick_nx = '0;
                    if (r_idx == 3'd4) begin
                        w_state_nx = S_CHECK;
                    end else begin
                        w_idx_nx   = r_idx + 3'd1;
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_tick_nx = r_tick + 1'b1;
                end
            end
            S_CHECK: begin
                w_idx_nx = 3'd0;
                if (w_op_legal) begin
                    w_cmd_op_nx    = r_frame[7:0];
                    w_cmd_data_nx  = r_frame[39:8];
                    w_cmd_valid_nx = 1'b1;
                    w_state_nx     = S_DELIVER;
                end else begin
                    w_frame_err_nx = 1'b1;
                    w_state_nx     = S_IDLE;
                end
            end
            S_DELIVER: begin
                if (bus.cmd_ready) begin
                    w_cmd_valid_nx = 1'b0;
                    w_state_nx     = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxf_m     <= 1'b1;
            r_rxf_s     <= 1'b1;
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_tick      <= '0;
            r_timer     <= 32'd0;
            r_rd        <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 8'h00;
            r_cmd_data  <= 32'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_rxf_m     <= bus.rxf;
            r_rxf_s     <= r_rxf_m;
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_tick      <= w_tick_nx;
            r_timer     <= w_timer_nx;
            r_rd        <= w_rd_nx;
            r_cmd_valid <= w_cmd_valid_nx;
            r_cmd_op    <= w_cmd_op_nx;
            r_cmd_data  <= w_cmd_data_nx;
            r_frame_err <= w_frame_err_nx;
        end
    end

    // Captured bytes are pure data; the byte index decides what is meaningful.
    always_ff @(posedge clk) begin
        r_frame <= w_frame_nx;
    end

    assign bus.rd        = r_rd;
    assign bus.wr        = 1'b1;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_cmd_op;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE) || (r_idx != 3'd0);
endmodule

// File: tb/tb_usb_command_receiver.sv
// Bench for usb_command_receiver: FT245 FIFO model, frame-level reference model,
// table-driven frames, hand-written corner sequences and randomized frames.
module tb_usb_command_receiver;
    localparam int L  = 2;
    localparam int H  = 2;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    usb_command_receiver_if bus ();

    usb_command_receiver #(
        .RD_LOW_TICKS (L),
        .RD_HIGH_TICKS(H),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic [39:0] bytes;   // byte0 in [39:32] ... byte4 in [7:0]
        int          hold;
        bit          exp_ok;
        logic [7:0]  op;
        logic [31:0] data;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [7:0] fifo[$];
    cmd_t       got_q[$];
    int         got_total = 0;
    int         err_cnt = 0;
    int         strobes = 0;
    int         cyc = 0;
    bit         ready_val = 1'b1;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [39:0] b);
        for (int k = 0; k < 5; k++) fifo.push_back(b[39-8*k -: 8]);
    endtask

    // FIFO model, handshake capture and protocol checks, all sampled on negedge.
    initial begin
        bit          rd_prev = 1'b1;
        bit          ferr_prev = 1'b0;
        bit          valid_prev = 1'b0;
        bit          ready_prev = 1'b0;
        logic [7:0]  op_prev = 8'h00;
        logic [31:0] data_prev = 32'd0;
        int          low_cnt = 0;
        int          last_fall = -1;
        bus.rxf       = 1'b1;
        bus.data_in   = 8'h00;
        bus.cmd_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rd_prev = 1'b1; ferr_prev = 1'b0; valid_prev = 1'b0;
                low_cnt = 0; last_fall = -1;
            end else begin
                if (!bus.rd) begin
                    if (rd_prev) begin
                        strobes++;
                        if (last_fall >= 0)
                            check("rd_fall_spacing", 64'((cyc - last_fall) >= (L + H)), 64'd1);
                        last_fall = cyc;
                    end
                    low_cnt++;
                end else if (!rd_prev) begin
                    check("rd_low_width", 64'(low_cnt), 64'(L));
                    low_cnt = 0;
                    if (fifo.size() > 0) void'(fifo.pop_front());
                end
                if (bus.cmd_valid) check("no_rd_while_valid", 64'(bus.rd), 64'd1);
                if (bus.cmd_valid && !valid_prev && last_fall >= 0)
                    check("valid_latency",
                          64'(((cyc - last_fall) >= (L + H + 1)) && ((cyc - last_fall) <= (L + H + 2))), 64'd1);
                if (bus.cmd_valid && valid_prev && !ready_prev) begin
                    check("hold_op_stable", 64'(bus.cmd_op), 64'(op_prev));
                    check("hold_data_stable", 64'(bus.cmd_data), 64'(data_prev));
                end
                if (bus.frame_err) begin
                    err_cnt++;
                    if (ferr_prev) check("frame_err_single_cycle", 64'd1, 64'd0);
                end
                rd_prev    = bus.rd;
                ferr_prev  = bus.frame_err;
                valid_prev = bus.cmd_valid;
                op_prev    = bus.cmd_op;
                data_prev  = bus.cmd_data;
            end
            bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
            // Outputs and ready now hold until the next posedge, so this is a transfer.
            if (!rst && bus.cmd_valid && bus.cmd_ready) begin
                got_q.push_back('{op: bus.cmd_op, data: bus.cmd_data});
                got_total++;
            end
            ready_prev  = bus.cmd_ready;
            bus.rxf     = (fifo.size() == 0);
            bus.data_in = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    task automatic wait_idle(input string name, input int max_cyc);
        int stable = 0;
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk);
            if (fifo.size() == 0 && !bus.busy && !bus.cmd_valid && bus.rd) stable++;
            else stable = 0;
            if (stable >= 4) break;
        end
        check(name, 64'(stable >= 4), 64'd1);
    endtask

    task automatic expect_cmd(input string name, input logic [7:0] op, input logic [31:0] data);
        cmd_t c;
        if (got_q.size() == 0) begin
            check({name, "_present"}, 64'd0, 64'd1);
        end else begin
            c = got_q.pop_front();
            check({name, "_op"}, 64'(c.op), 64'(op));
            check({name, "_data"}, 64'(c.data), 64'(data));
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int e0, g0, s0, s1, ng, ns;
        string nm;
        nm = $sformatf("vec%0d", n);
        e0 = err_cnt; g0 = got_total; s0 = strobes;
        ng = 1; ns = 5;
        ready_val = (v.hold == 0);
        push_frame(v.bytes);
        for (int t = 0; t < 400; t++) begin
            if (bus.cmd_valid || err_cnt != e0 || got_total != g0) break;
            @(negedge clk);
        end
        check({nm, "_outcome_seen"}, 64'(bus.cmd_valid || err_cnt != e0 || got_total != g0), 64'd1);
        if (v.hold > 0) begin
            // A second frame waits in the FIFO while the first is held back.
            push_frame(40'h01_EF_BE_AD_DE);
            ng = 2; ns = 10;
            s1 = strobes;
            repeat (v.hold) @(negedge clk);
            check({nm, "_held_valid"}, 64'(bus.cmd_valid), 64'd1);
            check({nm, "_no_rd_in_hold"}, 64'(strobes - s1), 64'd0);
            ready_val = 1'b1;
        end
        wait_idle({nm, "_idle"}, 2000);
        check({nm, "_strobes"}, 64'(strobes - s0), 64'(ns));
        if (v.exp_ok) begin
            check({nm, "_cmd_count"}, 64'(got_total - g0), 64'(ng));
            check({nm, "_no_err"}, 64'(err_cnt - e0), 64'd0);
            expect_cmd(nm, v.op, v.data);
            if (v.hold > 0) expect_cmd({nm, "_second"}, 8'h01, 32'hDEAD_BEEF);
        end else begin
            check({nm, "_cmd_count"}, 64'(got_total - g0), 64'd0);
            check({nm, "_err_count"}, 64'(err_cnt - e0), 64'd1);
            check({nm, "_busy_after"}, 64'(bus.busy), 64'd0);
            check({nm, "_valid_low"}, 64'(bus.cmd_valid), 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        cmd_t exp_q[$];
        int   e0, g0, s0, exp_err;

        vecs[0] = '{bytes: 40'h02_4C_06_00_00, hold: 0,  exp_ok: 1'b1, op: 8'h02, data: 32'h0000_064C};
        vecs[1] = '{bytes: 40'h00_00_00_00_00, hold: 20, exp_ok: 1'b1, op: 8'h00, data: 32'h0000_0000};
        vecs[2] = '{bytes: 40'h07_11_22_33_44, hold: 0,  exp_ok: 1'b0, op: 8'h00, data: 32'h0};
        vecs[3] = '{bytes: 40'h03_78_56_34_12, hold: 0,  exp_ok: 1'b1, op: 8'h03, data: 32'h1234_5678};
        vecs[4] = '{bytes: 40'h01_FF_FF_FF_FF, hold: 3,  exp_ok: 1'b1, op: 8'h01, data: 32'hFFFF_FFFF};
        vecs[5] = '{bytes: 40'h04_A5_A5_A5_A5, hold: 0,  exp_ok: 1'b0, op: 8'h00, data: 32'h0};
        vecs[6] = '{bytes: 40'hFF_00_00_00_00, hold: 0,  exp_ok: 1'b0, op: 8'h00, data: 32'h0};
        vecs[7] = '{bytes: 40'h02_80_00_00_01, hold: 0,  exp_ok: 1'b1, op: 8'h02, data: 32'h0100_0080};

        // Reset values, observed while reset is held.
        #2 rst = 1'b1;
        #1;
        check("rst_rd", 64'(bus.rd), 64'd1);
        check("rst_wr", 64'(bus.wr), 64'd1);
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        check("rst_cmd_op", 64'(bus.cmd_op), 64'h00);
        check("rst_cmd_data", 64'(bus.cmd_data), 64'h0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rd", 64'(bus.rd), 64'd1);
        check("idle_wr", 64'(bus.wr), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Partial frame abandoned by the idle timeout, then a fresh frame decodes.
        ready_val = 1'b1;
        e0 = err_cnt; s0 = strobes;
        push_frame(40'h03_14_00_00_00);
        void'(fifo.pop_back()); void'(fifo.pop_back()); void'(fifo.pop_back());
        for (int t = 0; t < 100; t++) begin
            if (strobes - s0 == 2 && fifo.size() == 0) break;
            @(negedge clk);
        end
        check("to_two_bytes_read", 64'(strobes - s0), 64'd2);
        repeat (90) @(negedge clk);
        check("to_not_early", 64'(err_cnt - e0), 64'd0);
        check("to_busy_partial", 64'(bus.busy), 64'd1);
        repeat (40) @(negedge clk);
        check("to_err_pulse", 64'(err_cnt - e0), 64'd1);
        check("to_busy_cleared", 64'(bus.busy), 64'd0);
        g0 = got_total;
        push_frame(40'h01_00_00_00_00);
        wait_idle("to_next_idle", 1000);
        check("to_next_count", 64'(got_total - g0), 64'd1);
        expect_cmd("to_next", 8'h01, 32'h0);

        // Reset while rd is low on byte2.
        s0 = strobes;
        push_frame(40'h01_AA_BB_CC_DD);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (strobes - s0 == 3 && !bus.rd) break;
        end
        check("mid_rst_reached_byte2", 64'((strobes - s0 == 3) && !bus.rd), 64'd1);
        #2 rst = 1'b1;
        fifo.delete();
        #1;
        check("mid_rst_rd_high", 64'(bus.rd), 64'd1);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
        check("mid_rst_op", 64'(bus.cmd_op), 64'h00);
        check("mid_rst_data", 64'(bus.cmd_data), 64'h0);
        check("mid_rst_ferr", 64'(bus.frame_err), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        e0 = err_cnt; g0 = got_total;
        push_frame(40'h02_01_02_03_04);
        wait_idle("mid_rst_next_idle", 1000);
        check("mid_rst_next_count", 64'(got_total - g0), 64'd1);
        check("mid_rst_next_no_err", 64'(err_cnt - e0), 64'd0);
        expect_cmd("mid_rst_next", 8'h02, 32'h0403_0201);

        // Back-to-back frames with the FIFO never running dry in between.
        g0 = got_total;
        push_frame(40'h03_10_20_30_40);
        push_frame(40'h00_AA_BB_CC_DD);
        wait_idle("b2b_idle", 2000);
        check("b2b_count", 64'(got_total - g0), 64'd2);
        expect_cmd("b2b_first", 8'h03, 32'h4030_2010);
        expect_cmd("b2b_second", 8'h00, 32'hDDCC_BBAA);

        // Random frames against the frame-level model, with random backpressure.
        rand_ready = 1'b1;
        e0 = err_cnt; g0 = got_total; exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0]  op;
            logic [31:0] d;
            op = 8'($urandom_range(0, 7));
            if (i % 5 == 4) op = 8'($urandom_range(8, 255));
            d  = $urandom;
            push_frame({op, d[7:0], d[15:8], d[23:16], d[31:24]});
            if (op <= 8'h03) exp_q.push_back('{op: op, data: d});
            else exp_err++;
        end
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (got_total - g0 == exp_q.size() && err_cnt - e0 == exp_err &&
                fifo.size() == 0 && !bus.busy) break;
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        check("rand_cmd_count", 64'(got_total - g0), 64'(exp_q.size()));
        check("rand_err_count", 64'(err_cnt - e0), 64'(exp_err));
        while (exp_q.size() > 0) begin
            cmd_t e;
            e = exp_q.pop_front();
            expect_cmd("rand", e.op, e.data);
        end
        wait_idle("final_idle", 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
